// File: rtl/rv_pkg.sv
// Shared fetch-stage types and constants: NOP encoding, queue entry layout, fetch FSM states.
// The entry carries an err bit only when FETCH_BUS_ERR_EN is defined.
package rv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] instr;
`ifdef FETCH_BUS_ERR_EN
        logic        err;
`endif
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_e;

    // Word-address increment; wraps 30'h3FFF_FFFF to zero.
    function automatic logic [29:0] pc_inc(input logic [29:0] pc);
        return pc + 30'd1;
    endfunction

endpackage

// File: rtl/rv_fetch_queue.sv
// Prefetch FIFO of {pc, instr[, err]} entries. Clear wins over push/pop.
// DEPTH must be a power of two and at least 2.
import rv_pkg::*;

module rv_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  fetch_entry_t           i_entry,
    output fetch_entry_t           o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE = (AW + 1)'(32'd1);
    localparam logic [AW:0]    CNT_ZERO = (AW + 1)'(32'd0);
    localparam logic [AW-1:0]  PTR_ONE = AW'(32'd1);
    localparam logic [AW-1:0]  PTR_ZERO = AW'(32'd0);

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;

    // Qualify push/pop so the FIFO can never overflow or underflow.
    always_comb begin
        push_s = i_push && (count_r != CNT_MAX);
        pop_s  = i_pop && (count_r != CNT_ZERO);
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (push_s && !i_clear) mem_r[wr_ptr_r] <= i_entry;
    end

    assign o_head  = mem_r[rd_ptr_r];
    assign o_full  = (count_r == CNT_MAX);
    assign o_empty = (count_r == CNT_ZERO);
    assign o_count = count_r;

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch stage: fetch PC, bus requests, prefetch queue and decode-aligned outputs.
// Optional bus-error handling (fault FSM, i_ibus_err, o_fetch_fault) under FETCH_BUS_ERR_EN.
import rv_pkg::*;

module rv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          QUEUE_DEPTH  = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:2] i_pc_target,
    output logic        o_ibus_req,
    output logic [31:2] o_ibus_addr,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_rdata,
`ifdef FETCH_BUS_ERR_EN
    input  logic        i_ibus_err,
    output logic        o_fetch_fault,
`endif
    output logic [31:2] o_pc,
    output logic [31:2] o_pc_p4,
    output logic [31:0] o_data
);

    localparam int             CW       = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C  = CW'(QUEUE_DEPTH);
    localparam logic [31:2]    RESET_PC = RESET_VECTOR[31:2];

    logic [31:2]   fetch_pc_r;
    logic [31:0]   data_r;
    logic          run_s;
    logic          req_s;
    logic          push_s;
    logic          pop_s;
    fetch_entry_t  entry_s;
    fetch_entry_t  head_s;
    logic          q_full_s;
    logic          q_empty_s;
    logic [CW-1:0] q_count_s;

    rv_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (push_s),
        .i_pop     (pop_s),
        .i_clear   (i_flush),
        .i_entry   (entry_s),
        .o_head    (head_s),
        .o_full    (q_full_s),
        .o_empty   (q_empty_s),
        .o_count   (q_count_s)
    );

`ifdef FETCH_BUS_ERR_EN
    fetch_state_e state_r;
    fetch_state_e state_next_s;
    logic         fault_r;

    assign run_s = (state_r == FETCH_RUN);

    // Fault FSM: a bus error stops fetching until the next redirect.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH_RUN: begin
                if (i_flush)                     state_next_s = FETCH_RUN;
                else if (push_s && i_ibus_err)   state_next_s = FETCH_FAULT;
                else                             state_next_s = FETCH_RUN;
            end
            FETCH_FAULT: begin
                if (i_flush) state_next_s = FETCH_RUN;
                else         state_next_s = FETCH_FAULT;
            end
            default: state_next_s = FETCH_RUN;
        endcase
    end

    // Fault FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state_r <= FETCH_RUN;
        else            state_r <= state_next_s;
    end

    // Fault flag travels with o_data: set when the erroring entry is accepted by decode.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)     fault_r <= 1'b0;
        else if (i_flush)   fault_r <= 1'b0;
        else if (!i_stall)  fault_r <= !q_empty_s && head_s.err;
        else                fault_r <= fault_r;
    end

    assign o_fetch_fault = fault_r;
`else
    assign run_s = 1'b1;
`endif

    // Request, push/pop qualification and the entry to enqueue.
    always_comb begin
        req_s         = (q_count_s < DEPTH_C) && !i_flush && run_s;
        push_s        = req_s && i_ibus_ack && !q_full_s;
        pop_s         = !i_stall && !i_flush && !q_empty_s;
        entry_s.pc    = fetch_pc_r;
`ifdef FETCH_BUS_ERR_EN
        entry_s.err   = i_ibus_err;
        if (i_ibus_err) entry_s.instr = RV_NOP;
        else            entry_s.instr = i_ibus_rdata;
`else
        entry_s.instr = i_ibus_rdata;
`endif
    end

    // Fetch PC: redirect beats everything; otherwise advance on each completed read.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)   fetch_pc_r <= RESET_PC;
        else if (i_flush) fetch_pc_r <= i_pc_target;
        else if (push_s)  fetch_pc_r <= pc_inc(fetch_pc_r);
        else              fetch_pc_r <= fetch_pc_r;
    end

    // Lag register: the word decode sees one cycle after it accepted the matching PC.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)    data_r <= RV_NOP;
        else if (i_flush)  data_r <= RV_NOP;
        else if (!i_stall) data_r <= q_empty_s ? RV_NOP : head_s.instr;
        else               data_r <= data_r;
    end

    // Head presentation; an empty queue shows a zero-PC bubble.
    always_comb begin
        o_pc    = 30'd0;
        o_pc_p4 = 30'd0;
        if (!q_empty_s) begin
            o_pc    = head_s.pc;
            o_pc_p4 = pc_inc(head_s.pc);
        end else begin
            o_pc    = 30'd0;
            o_pc_p4 = 30'd0;
        end
    end

    assign o_ibus_req  = req_s;
    assign o_ibus_addr = fetch_pc_r;
    assign o_data      = data_r;

endmodule

// File: tb/tb_rv_fetch.sv
// Self-checking bench for rv_fetch: a reference queue/PC model acts as scoreboard,
// entries pushed on modelled acks and popped as decode accepts them.
module tb_rv_fetch;
    import rv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] VEC   = 32'h0000_0100;
`ifdef FETCH_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, stall, flush, ack, err;
    logic [29:0] target, addr, pc, pc_p4;
    logic        req;
    logic [31:0] rdata, data;
`ifdef FETCH_BUS_ERR_EN
    logic        fault;
`endif

    always #5 clk = ~clk;

    rv_fetch #(.RESET_VECTOR(VEC), .QUEUE_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_pc_target  (target),
        .o_ibus_req   (req),
        .o_ibus_addr  (addr),
        .i_ibus_ack   (ack),
        .i_ibus_rdata (rdata),
`ifdef FETCH_BUS_ERR_EN
        .i_ibus_err   (err),
        .o_fetch_fault(fault),
`endif
        .o_pc         (pc),
        .o_pc_p4      (pc_p4),
        .o_data       (data)
    );

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a[27:0], 4'h7} ^ 32'h5A00_0000;
    endfunction

    assign rdata = mem_word(addr);

    typedef struct { logic [29:0] pc; logic [31:0] instr; logic err; } mq_t;
    mq_t         mq[$];
    logic [29:0] m_pc;
    logic [31:0] m_data;
    logic        m_fault, m_fault_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        s_req;
    logic [29:0] s_addr, s_pc, s_p4;
    logic [31:0] s_data;

    // One clock cycle: drive, sample mid-low-phase, compare against the model, advance model.
    task automatic step(input logic s, input logic f, input logic a, input logic e, input logic [29:0] t);
        logic        exp_req, do_push, e_eff;
        logic [29:0] exp_pc, exp_p4;
        mq_t         h;
        stall = s; flush = f; ack = a; err = e; target = t;
        #2;
        s_req = req; s_addr = addr; s_pc = pc; s_p4 = pc_p4; s_data = data;
        exp_req = (mq.size() < DEPTH) && !f && !m_fault;
        if (mq.size() > 0) begin
            exp_pc = mq[0].pc;
            exp_p4 = mq[0].pc + 30'd1;
        end else begin
            exp_pc = 30'd0;
            exp_p4 = 30'd0;
        end
        n_checks++;
        if (req !== exp_req) begin n_fail++; $display("FAIL req: got %b expected %b at %0t", req, exp_req, $time); end
        if (exp_req) begin
            n_checks++;
            if (addr !== m_pc) begin n_fail++; $display("FAIL addr: got %h expected %h at %0t", addr, m_pc, $time); end
        end
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL pc: got %h expected %h at %0t", pc, exp_pc, $time); end
        n_checks++;
        if (pc_p4 !== exp_p4) begin n_fail++; $display("FAIL pc_p4: got %h expected %h at %0t", pc_p4, exp_p4, $time); end
        n_checks++;
        if (data !== m_data) begin n_fail++; $display("FAIL data: got %h expected %h at %0t", data, m_data, $time); end
`ifdef FETCH_BUS_ERR_EN
        n_checks++;
        if (fault !== m_fault_out) begin n_fail++; $display("FAIL fault: got %b expected %b at %0t", fault, m_fault_out, $time); end
`endif
        do_push = exp_req && a;
        e_eff   = ERR_EN && e;
        if (f) begin
            mq.delete();
            m_data = RV_NOP; m_pc = t; m_fault = 1'b0; m_fault_out = 1'b0;
        end else begin
            if (!s) begin
                if (mq.size() > 0) begin
                    h = mq.pop_front();
                    m_data = h.instr; m_fault_out = h.err;
                end else begin
                    m_data = RV_NOP; m_fault_out = 1'b0;
                end
            end
            if (do_push) begin
                mq.push_back('{pc: m_pc, instr: (e_eff ? RV_NOP : mem_word(m_pc)), err: e_eff});
                m_pc = m_pc + 30'd1;
                if (e_eff) m_fault = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b1; err = 1'b0; target = 30'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        n_checks++; if (pc !== 30'd0)     begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc); end
        n_checks++; if (pc_p4 !== 30'd0)  begin n_fail++; $display("FAIL reset_pc_p4: got %h expected 0", pc_p4); end
        n_checks++; if (data !== RV_NOP)  begin n_fail++; $display("FAIL reset_data: got %h expected %h", data, RV_NOP); end
        n_checks++; if (req !== 1'b1)     begin n_fail++; $display("FAIL reset_req: got %b expected 1", req); end
        reset_n = 1'b1;
        mq.delete();
        m_pc = VEC[31:2]; m_data = RV_NOP; m_fault = 1'b0; m_fault_out = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_addr !== 30'h40) begin n_fail++; $display("FAIL c0_addr: got %h expected 40", s_addr); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_pc !== 30'h40) begin n_fail++; $display("FAIL c1_pc: got %h expected 40", s_pc); end
        n_checks++; if (s_p4 !== 30'h41) begin n_fail++; $display("FAIL c1_pc_p4: got %h expected 41", s_p4); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_data !== mem_word(30'h40)) begin n_fail++; $display("FAIL c2_data: got %h expected %h", s_data, mem_word(30'h40)); end
        n_checks++; if (s_addr !== 30'h42) begin n_fail++; $display("FAIL c2_addr: got %h expected 42", s_addr); end
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
    endtask

    task automatic test_stall();
        logic r [3];
        logic [29:0] p [3];
        step(1'b0, 1'b1, 1'b1, 1'b0, 30'h10);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 30'd0);
            r[k] = s_req; p[k] = s_pc;
            n_checks++; if (s_data !== RV_NOP) begin n_fail++; $display("FAIL stall_data: got %h expected %h", s_data, RV_NOP); end
        end
        n_checks++; if (r[0] !== 1'b1 || r[1] !== 1'b1 || r[2] !== 1'b0) begin
            n_fail++; $display("FAIL stall_req_pattern: got %b%b%b expected 110", r[0], r[1], r[2]); end
        n_checks++; if (p[1] !== 30'h10 || p[2] !== 30'h10) begin
            n_fail++; $display("FAIL stall_pc_frozen: got %h %h expected 10 10", p[1], p[2]); end
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
    endtask

    task automatic test_flush_ack();
        step(1'b0, 1'b1, 1'b1, 1'b0, 30'h80);
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_addr !== 30'h80 || s_req !== 1'b1) begin
            n_fail++; $display("FAIL flush_addr: got req %b addr %h expected req 1 addr 80", s_req, s_addr); end
        n_checks++; if (s_data !== RV_NOP) begin n_fail++; $display("FAIL flush_data: got %h expected %h", s_data, RV_NOP); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_pc !== 30'h80) begin n_fail++; $display("FAIL flush_pc: got %h expected 80", s_pc); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_data !== mem_word(30'h80)) begin n_fail++; $display("FAIL flush_word: got %h expected %h", s_data, mem_word(30'h80)); end
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
    endtask

    task automatic test_ack_low();
        logic [29:0] a0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
            if (k == 0) a0 = s_addr;
            n_checks++; if (s_addr !== a0) begin n_fail++; $display("FAIL acklow_addr: got %h expected %h", s_addr, a0); end
            if (k >= 1) begin
                n_checks++; if (s_pc !== 30'd0) begin n_fail++; $display("FAIL acklow_pc: got %h expected 0", s_pc); end
            end
            if (k >= 2) begin
                n_checks++; if (s_data !== RV_NOP) begin n_fail++; $display("FAIL acklow_data: got %h expected %h", s_data, RV_NOP); end
            end
        end
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b0, 1'b0, 30'h3FFF_FFFF);
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_addr !== 30'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap_addr0: got %h expected 3fffffff", s_addr); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_addr !== 30'd0) begin n_fail++; $display("FAIL wrap_addr1: got %h expected 0", s_addr); end
        n_checks++; if (s_pc !== 30'h3FFF_FFFF || s_p4 !== 30'd0) begin
            n_fail++; $display("FAIL wrap_pc: got %h/%h expected 3fffffff/0", s_pc, s_p4); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_data !== mem_word(30'h3FFF_FFFF)) begin
            n_fail++; $display("FAIL wrap_data: got %h expected %h", s_data, mem_word(30'h3FFF_FFFF)); end
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 120; k++)
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 11) == 0), 30'($urandom));
        step(1'b0, 1'b1, 1'b1, 1'b0, 30'h1000);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
    endtask

`ifdef FETCH_BUS_ERR_EN
    task automatic test_bus_err();
        step(1'b0, 1'b1, 1'b0, 1'b0, 30'h300);
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 30'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL err_req_off: got %b expected 0", s_req); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (fault !== 1'b1 || s_data !== RV_NOP) begin
            n_fail++; $display("FAIL err_fault: got fault %b data %h expected 1 %h", fault, s_data, RV_NOP); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (fault !== 1'b0 || s_req !== 1'b0) begin
            n_fail++; $display("FAIL err_after: got fault %b req %b expected 0 0", fault, s_req); end
        step(1'b0, 1'b1, 1'b1, 1'b0, 30'h400);
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        n_checks++; if (s_req !== 1'b1 || s_addr !== 30'h400) begin
            n_fail++; $display("FAIL err_resume: got req %b addr %h expected 1 400", s_req, s_addr); end
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_stall();
        test_flush_ack();
        test_ack_low();
        test_wrap();
`ifdef FETCH_BUS_ERR_EN
        test_bus_err();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv_fetch.md
# rv_fetch

Instruction fetch stage directly upstream of the decode stage.
- Owns the fetch PC and issues word reads on the instruction bus.
- Buffers returned words in a small prefetch queue.
- Presents PC / PC+4 to decode one cycle ahead of the matching instruction word, so decode's registered PC lines up with the word it decodes.
- Honours the shared pipeline `i_stall` / `i_flush` controls. On flush it redirects to `i_pc_target`.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: byte address of the first fetch; bits [1:0] ignored.
- `QUEUE_DEPTH`, default 2: prefetch queue entries; power of two, ≥2.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset_n`  in  1  reset; synchronous, active-low.
- `i_stall`  in  1  decode stage holding; no pop, outputs hold.
- `i_flush`  in  1  redirect; discards queue and in-flight data.
- `i_pc_target`  in  [31:2]  redirect word address, sampled when `i_flush`=1.
- `o_ibus_req`  out  1  read request.
- `o_ibus_addr`  out  [31:2]  read word address.
- `i_ibus_ack`  in  1  transfer completes in a cycle with `req`&&`ack`.
- `i_ibus_rdata`  in  [31:0]  read data, valid when `req`&&`ack`.
- `o_pc`  out  [31:2]  PC for decode's PC register.
- `o_pc_p4`  out  [31:2]  `o_pc`+1 (word), modulo 2^30.
- `o_data`  out  [31:0]  instruction word matching the `o_pc` presented in the previous accepted cycle.

## Operation
- State:
  - `r_fetch_pc` [31:2]
  - queue of {pc, instr} entries
  - `r_data` [31:0] lag register driving `o_data`
- Bus requests:
  - `o_ibus_req` = (count < `QUEUE_DEPTH`) && !`i_flush` (plus fault-state gating, see Configuration).
  - `o_ibus_addr` = `r_fetch_pc`.
- On `req`&&`ack`:
  - push {`r_fetch_pc`, `i_ibus_rdata`}.
  - `r_fetch_pc` += 1; wraps 30'h3FFF_FFFF → 0.
- Head presentation (combinational):
  - Queue non-empty: `o_pc` = head pc, `o_pc_p4` = head pc+1.
  - Queue empty: both are 0 (bubble).
- Pop occurs when !`i_stall` && !`i_flush` && non-empty. In that cycle `r_data` <= head instr.
- When !`i_stall` && empty: `r_data` <= NOP (32'h0000_0013).
- When `i_stall`: queue head and `r_data` hold; pushes still allowed while not full.
- Push and pop in the same cycle: count unchanged. When full, no request is made even if a pop occurs that cycle.
- Flush has priority over stall, push and pop:
  - queue cleared
  - `r_data` <= NOP
  - `r_fetch_pc` <= `i_pc_target`
  - any data acked in the flush cycle is discarded
- Reset: `r_fetch_pc` = `RESET_VECTOR`[31:2], queue empty, `r_data` = NOP.
  - Outputs after reset: `o_pc`=0, `o_pc_p4`=0, `o_data`=NOP, `o_ibus_req`=1.

## Timing
- Zero-wait bus (ack in the cycle of req):
  - First reset-released cycle C0: push.
  - C1: `o_pc` = vector; decode registers it at the end of C1.
  - C2: `o_data` = word.
- Redirect: flush in cycle F → request to target in F+1 → target on `o_pc` at F+2 → its word on `o_data` at F+3.
- Sustained throughput: one instruction per cycle with zero-wait ack and no stall.
- `o_ibus_addr` is stable while `req`=1 and `ack`=0, except in the cycle following a flush.

## Configuration
- Macro `FETCH_BUS_ERR_EN`.
- Defined, the block adds:
  - port `i_ibus_err` (in, 1), qualified with `req`&&`ack`
  - port `o_fetch_fault` (out, 1, reset 0), registered alongside `o_data`
  - an err bit in each queue entry
- Defined, behaviour:
  - An erroring word is pushed as NOP with err=1.
  - The FSM moves RUN → FAULT.
  - FAULT: `o_ibus_req`=0; queued entries still drain.
  - When the err entry pops, `o_data`=NOP and `o_fetch_fault`=1 for one accepted cycle.
  - Flush returns FAULT → RUN.
- Undefined: no err ports, no FAULT state; bus errors are not observable.

## Structure
- Shared package `rv_pkg`:
  - `RV_NOP` constant
  - `fetch_entry_t` struct {pc[31:2], instr[31:0], err when enabled}
  - fetch FSM state enum
- Sub-module `rv_fetch_queue`: synchronous FIFO with push, pop, clear, full, empty and count; depth `QUEUE_DEPTH`.
- The PC, bus and FSM logic live in `rv_fetch`.

## Test plan
- Reset with `RESET_VECTOR`=32'h100 and ack tied 1 → addresses 0x40,0x41,0x42 words; `o_pc`=0x40 at C1; `o_data`=mem[0x100] at C2; `o_pc_p4`=0x41.
- Hold `i_stall` 3 cycles with ack=1 → exactly 2 pushes then `req`=0; `o_pc` / `o_data` frozen; release → in-order continuation with no loss or duplicate.
- Flush with target 0x200 while an ack arrives in the same cycle → acked word discarded; next request addr 0x80 words; `o_data`=NOP for one cycle.
- ack held low 4 cycles → `o_pc`=0 and `o_data`=NOP bubbles; `o_ibus_addr` stable throughout.
- Fetch PC 30'h3FFF_FFFF → next address 0; `o_pc_p4`=0 for that entry.
- `FETCH_BUS_ERR_EN`: err on second fetch → `o_fetch_fault`=1 with `o_data`=NOP two cycles after that word is pushed; `req`=0 until flush; flush resumes at target.
